// File: rtl/rom_arbiter2.sv
`default_nettype none
// ============================================================================
// Module   : rom_arbiter2
// Purpose  : Two-port round-robin arbiter for the single combinational read
//            port of a 16x8 distributed ROM. Registers the winning address
//            into the ROM, captures rom_spo one cycle later and returns it to
//            the winner with a one-cycle acknowledge. One access in flight.
// Ports    : clk, rst               - clock, synchronous active-high reset
//            req0/addr0/ack0/rdata0 - client port 0
//            req1/addr1/ack1/rdata1 - client port 1
//            rom_a (out), rom_spo (in) - ROM address / data
//            busy                   - high while a ROM read is being captured
// Revision : 1.0 - initial release
// ============================================================================
module rom_arbiter2 #(
    parameter int AW = 4,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic [AW-1:0] addr0,
    output logic          ack0,
    output logic [DW-1:0] rdata0,
    input  logic          req1,
    input  logic [AW-1:0] addr1,
    output logic          ack1,
    output logic [DW-1:0] rdata1,
    output logic [AW-1:0] rom_a,
    input  logic [DW-1:0] rom_spo,
    output logic          busy
);

    typedef enum logic [0:0] {
        c_ST_IDLE = 1'b0,
        c_ST_READ = 1'b1
    } state_t;

    state_t        r_state_q, w_state_d;
    logic [AW-1:0] r_rom_a_q, w_rom_a_d;
    logic [DW-1:0] r_rdata0_q, w_rdata0_d;
    logic [DW-1:0] r_rdata1_q, w_rdata1_d;
    logic          r_ack0_q, w_ack0_d;
    logic          r_ack1_q, w_ack1_d;
    logic          r_sel_q, w_sel_d;
    logic          r_last_q, w_last_d;

    logic          w_elig0;
    logic          w_elig1;

    // A request seen in the same cycle as its own ack is the tail of the
    // access just completed, not a new one, so it is masked.
    assign w_elig0 = req0 & ~r_ack0_q;
    assign w_elig1 = req1 & ~r_ack1_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q  <= c_ST_IDLE;
            r_rom_a_q  <= '0;
            r_rdata0_q <= '0;
            r_rdata1_q <= '0;
            r_ack0_q   <= 1'b0;
            r_ack1_q   <= 1'b0;
            r_sel_q    <= 1'b0;
            r_last_q   <= 1'b1;   // port 0 wins the first tie
        end else begin
            r_state_q  <= w_state_d;
            r_rom_a_q  <= w_rom_a_d;
            r_rdata0_q <= w_rdata0_d;
            r_rdata1_q <= w_rdata1_d;
            r_ack0_q   <= w_ack0_d;
            r_ack1_q   <= w_ack1_d;
            r_sel_q    <= w_sel_d;
            r_last_q   <= w_last_d;
        end
    end

    always_comb begin
        w_state_d  = r_state_q;
        w_rom_a_d  = r_rom_a_q;
        w_rdata0_d = r_rdata0_q;
        w_rdata1_d = r_rdata1_q;
        w_ack0_d   = 1'b0;
        w_ack1_d   = 1'b0;
        w_sel_d    = r_sel_q;
        w_last_d   = r_last_q;

        case (r_state_q)
            c_ST_IDLE: begin
                if (w_elig0 || w_elig1) begin
                    // On a tie the port that was not served last wins.
                    if (w_elig0 && w_elig1) begin
                        w_sel_d = ~r_last_q;
                    end else begin
                        w_sel_d = w_elig1;
                    end
                    w_rom_a_d = w_sel_d ? addr1 : addr0;
                    w_state_d = c_ST_READ;
                end
            end
            c_ST_READ: begin
                // rom_a has been stable for a full cycle; capture the data.
                if (r_sel_q) begin
                    w_rdata1_d = rom_spo;
                    w_ack1_d   = 1'b1;
                end else begin
                    w_rdata0_d = rom_spo;
                    w_ack0_d   = 1'b1;
                end
                w_last_d  = r_sel_q;
                w_state_d = c_ST_IDLE;
            end
            default: begin
                w_state_d = c_ST_IDLE;
            end
        endcase
    end

    assign ack0   = r_ack0_q;
    assign ack1   = r_ack1_q;
    assign rdata0 = r_rdata0_q;
    assign rdata1 = r_rdata1_q;
    assign rom_a  = r_rom_a_q;
    assign busy   = (r_state_q == c_ST_READ);

endmodule
`default_nettype wire

// File: tb/tb_rom_arbiter2.sv
`default_nettype none
// ============================================================================
// Module   : tb_rom_arbiter2
// Purpose  : Self-checking bench for rom_arbiter2. Directed steps drive the
//            client ports; each expected (port, data) ack is queued when the
//            request is driven and popped by a monitor when an ack appears.
//            ROM model: rom_spo = rom_a * 0x11.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rom_arbiter2;

    localparam int AW = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0, req1;
    logic [AW-1:0] addr0, addr1;
    logic          ack0, ack1;
    logic [DW-1:0] rdata0, rdata1;
    logic [AW-1:0] rom_a;
    logic [DW-1:0] rom_spo;
    logic          busy;

    int            vectors     = 0;
    int            miscompares = 0;
    logic [DW:0]   sb_q[$];
    logic [DW:0]   mon_exp;

    rom_arbiter2 #(.AW(AW), .DW(DW)) dut (
        .clk     (clk),
        .rst     (rst),
        .req0    (req0),
        .addr0   (addr0),
        .ack0    (ack0),
        .rdata0  (rdata0),
        .req1    (req1),
        .addr1   (addr1),
        .ack1    (ack1),
        .rdata1  (rdata1),
        .rom_a   (rom_a),
        .rom_spo (rom_spo),
        .busy    (busy)
    );

    assign rom_spo = {4'h0, rom_a} * 8'h11;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic port, input logic [DW-1:0] data);
        sb_q.push_back({port, data});
    endtask

    // Scoreboard monitor: every ack must match the oldest queued expectation.
    always @(negedge clk) begin
        if (ack0 || ack1) begin
            check("ack_exclusive", 32'(ack0 & ack1), 32'd0);
            check("sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
            if (sb_q.size() > 0) begin
                mon_exp = sb_q.pop_front();
                check("sb_port", 32'(ack1), 32'(mon_exp[DW]));
                check("sb_data", 32'(ack1 ? rdata1 : rdata0), 32'(mon_exp[DW-1:0]));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0;
        step();
        step();
        check("rst_ack0",   32'(ack0),   32'd0);
        check("rst_ack1",   32'(ack1),   32'd0);
        check("rst_rdata0", 32'(rdata0), 32'd0);
        check("rst_rdata1", 32'(rdata1), 32'd0);
        check("rst_rom_a",  32'(rom_a),  32'd0);
        check("rst_busy",   32'(busy),   32'd0);
        rst = 1'b0;

        // Single request, addr 3: busy at T+1, ack at T+2 for one cycle.
        req0 = 1'b1; addr0 = 4'd3; push(1'b0, 8'h33);
        step();
        check("t1_busy",    32'(busy),  32'd1);
        check("t1_ack0_t1", 32'(ack0),  32'd0);
        check("t1_rom_a",   32'(rom_a), 32'd3);
        step();
        check("t1_ack0",    32'(ack0),   32'd1);
        check("t1_rdata0",  32'(rdata0), 32'h33);
        req0 = 1'b0;
        step();
        check("t1_ack0_pulse", 32'(ack0),   32'd0);
        check("t1_ack1",       32'(ack1),   32'd0);
        check("t1_rdata0_hold",32'(rdata0), 32'h33);
        check("t1_rdata1",     32'(rdata1), 32'd0);

        // Simultaneous requests after reset: port 0 first, port 1 2 cycles later.
        rst = 1'b1;
        step();
        rst = 1'b0;
        req0 = 1'b1; addr0 = 4'd5; req1 = 1'b1; addr1 = 4'd10;
        push(1'b0, 8'h55); push(1'b1, 8'hAA);
        step();
        step();
        check("t2_ack0",   32'(ack0),   32'd1);
        check("t2_rdata0", 32'(rdata0), 32'h55);
        req0 = 1'b0;
        step();
        check("t2_gap_ack1", 32'(ack1), 32'd0);
        step();
        check("t2_ack1",   32'(ack1),   32'd1);
        check("t2_rdata1", 32'(rdata1), 32'hAA);
        check("t2_ack0_lo",32'(ack0),   32'd0);
        req1 = 1'b0;
        step();

        // Both held for 8 accesses: acks alternate 0,1,0,1 every 2 cycles.
        req0 = 1'b1; addr0 = 4'd1; req1 = 1'b1; addr1 = 4'd2;
        for (int i = 0; i < 8; i++) push(1'(i % 2), (i % 2) ? 8'h22 : 8'h11);
        for (int i = 0; i < 8; i++) begin
            step();
            check("t3_busy", 32'(busy), 32'd1);
            step();
            check("t3_ack0", 32'(ack0), 32'((i % 2) == 0));
            check("t3_ack1", 32'(ack1), 32'((i % 2) == 1));
            check("t3_rdata0", 32'(rdata0), 32'h11);
            if (i > 0) check("t3_rdata1", 32'(rdata1), 32'h22);
            if (i == 7) begin
                req0 = 1'b0; req1 = 1'b0;
            end
        end
        step();
        check("t3_idle", 32'(busy), 32'd0);

        // Single port held, address stepping 0..15: one ack every 3 cycles.
        req0 = 1'b1; addr0 = 4'd0;
        for (int i = 0; i < 16; i++) begin
            push(1'b0, 8'(i * 8'h11));
            step();
            check("t4_busy", 32'(busy), 32'd1);
            step();
            check("t4_ack0",   32'(ack0),   32'd1);
            check("t4_rdata0", 32'(rdata0), 32'(i * 8'h11));
            if (i == 15) req0 = 1'b0;
            else addr0 = 4'(i + 1);
            step();
            check("t4_masked_busy", 32'(busy), 32'd0);
            check("t4_masked_ack0", 32'(ack0), 32'd0);
        end

        // Reset in the READ cycle of a port 1 access: discarded, then re-served.
        req1 = 1'b1; addr1 = 4'd7; push(1'b1, 8'h77);
        step();
        check("t5_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        step();
        check("t5_no_ack1", 32'(ack1),   32'd0);
        check("t5_rdata1",  32'(rdata1), 32'd0);
        check("t5_rom_a",   32'(rom_a),  32'd0);
        check("t5_busy_rst",32'(busy),   32'd0);
        rst = 1'b0;
        step();
        check("t5_rebusy", 32'(busy), 32'd1);
        step();
        check("t5_ack1",   32'(ack1),   32'd1);
        check("t5_rdata1b",32'(rdata1), 32'h77);
        req1 = 1'b0;
        step();

        // Address change after grant does not affect the access in flight.
        req0 = 1'b1; addr0 = 4'd4; push(1'b0, 8'h44);
        step();
        check("t6_rom_a", 32'(rom_a), 32'd4);
        addr0 = 4'd9;
        step();
        check("t6_ack0",   32'(ack0),   32'd1);
        check("t6_rdata0", 32'(rdata0), 32'h44);
        req0 = 1'b0;
        step();
        step();
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
